// File: rtl/hazard_pkg.sv
// Shared types and helpers for the sequential pipeline hazard unit.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   localparam int unsigned SRC_B_ONLY = 12;

   // Down-counter width: enough to hold max(LOAD_STALL, FLUSH_CYC), never zero.
   function automatic int unsigned cnt_width(input int unsigned ls, input int unsigned fc);
      int unsigned m;
      int unsigned w;
      m = (ls > fc) ? ls : fc;
      w = $clog2(m + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/hazard_unit_seq.sv
// Sequential load-use / branch hazard unit with multi-cycle stall and flush,
// memory-busy freeze and saturating performance counters.
module hazard_unit_seq
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW         = 2,
   parameter int unsigned OPC_W          = 4,
   parameter int unsigned SRC_B_ONLY_OPC = SRC_B_ONLY,
   parameter int unsigned LOAD_STALL     = 1,
   parameter int unsigned FLUSH_CYC      = 1,
   parameter int unsigned CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] if_id_ra,
   input  logic [REG_AW-1:0] if_id_rb,
   input  logic [REG_AW-1:0] id_ex_rd,
   input  logic              id_ex_mem_read,
   input  logic [OPC_W-1:0]  opcode,
   input  logic              bt,
   input  logic              mem_busy,
   output logic              pc_en,
   output logic              if_id_en,
   output logic              id_ex_en,
   output logic              flush,
   output logic              control_zero,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   localparam int unsigned CW = cnt_width(LOAD_STALL, FLUSH_CYC);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          hz;

   assign hz = id_ex_mem_read &
               ((id_ex_rd == if_id_rb) |
                ((opcode != OPC_W'(SRC_B_ONLY_OPC)) & (id_ex_rd == if_id_ra)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Priority: reset defaults > mem_busy freeze > taken branch > load-use.
   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      flush        = 1'b0;
      control_zero = 1'b0;
      if (!rst_n) begin
         state_n = RUN;
         cnt_n   = '0;
      end else if (mem_busy) begin
         pc_en    = 1'b0;
         if_id_en = 1'b0;
         id_ex_en = 1'b0;
      end else if (bt) begin
         flush = 1'b1;
         if (FLUSH_CYC > 1) begin
            state_n = FLUSH;
            cnt_n   = CW'(FLUSH_CYC - 2);
         end else begin
            state_n = RUN;
         end
      end else begin
         case (state)
            FLUSH: begin
               flush = 1'b1;
               if (cnt == '0) state_n = RUN;
               else           cnt_n   = cnt - CW'(1);
            end
            LU_STALL: begin
               pc_en        = 1'b0;
               if_id_en     = 1'b0;
               control_zero = 1'b1;
               if (cnt == '0) state_n = RUN;
               else           cnt_n   = cnt - CW'(1);
            end
            RUN: begin
               if (hz) begin
                  pc_en        = 1'b0;
                  if_id_en     = 1'b0;
                  control_zero = 1'b1;
                  if (LOAD_STALL > 1) begin
                     state_n = LU_STALL;
                     cnt_n   = CW'(LOAD_STALL - 2);
                  end
               end
            end
            default: begin
               state_n = RUN;
               cnt_n   = '0;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clear (~rst_n),
      .inc   (control_zero),
      .count (stall_count)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clear (~rst_n),
      .inc   (flush),
      .count (flush_count)
   );

endmodule
